// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : CP0 exception/interrupt controller (SR, Cause, EPC) for the
//            M stage. Optional macro EXC_CTRL_BD_EN enables delay-slot support.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  M_ExcCode,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic        M_eret,
    input  logic [5:0]  HWInt,
    input  logic        CP0_we,
    input  logic [4:0]  CP0_addr,
    input  logic [31:0] CP0_wdata,
    output logic [31:0] CP0_rdata,
    output logic        Req,
    output logic [31:0] EPC,
    output logic        EXL
);

    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_im;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic        r_bd;
    logic [31:0] r_epc;

    logic        w_run;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_pc_aligned;
    logic [31:0] w_trap_epc;
    logic        w_trap_bd;

    assign w_run        = (r_state == ST_RUN);
    // Interrupt detection uses the live lines so the trap is taken this cycle.
    assign w_int_req    = (|(HWInt & r_im)) & r_ie & w_run;
    assign w_exc_req    = (M_ExcCode != 5'd0) & w_run;
    assign Req          = w_int_req | w_exc_req;
    assign EXL          = (r_state == ST_SERVE);
    assign EPC          = r_epc;

    // A trap in the same cycle always wins over an mtc0.
    assign w_wr_sr      = CP0_we & ~Req & (CP0_addr == c_ADDR_SR);
    assign w_wr_epc     = CP0_we & ~Req & (CP0_addr == c_ADDR_EPC);

    assign w_pc_aligned = {M_PC[31:2], 2'b00};

`ifdef EXC_CTRL_BD_EN
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^M_PC[1:0];
    assign w_trap_epc      = M_BD ? (w_pc_aligned - 32'd4) : w_pc_aligned;
    assign w_trap_bd       = M_BD;
`else
    logic w_unused_bits;
    assign w_unused_bits   = ^{M_BD, M_PC[1:0]};
    assign w_trap_epc      = w_pc_aligned;
    assign w_trap_bd       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (Req) begin
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (M_eret) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_im  <= 6'd0;
            r_ie  <= 1'b0;
            r_ip  <= 6'd0;
            r_exc <= 5'd0;
            r_bd  <= 1'b0;
            r_epc <= 32'd0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_epc <= w_trap_epc;
                r_exc <= w_int_req ? 5'd0 : M_ExcCode;
                r_bd  <= w_trap_bd;
            end else if (w_wr_epc) begin
                r_epc <= CP0_wdata;
            end
            if (w_wr_sr) begin
                r_im <= CP0_wdata[15:10];
                r_ie <= CP0_wdata[0];
            end
        end
    end

    always_comb begin
        CP0_rdata = 32'd0;
        case (CP0_addr)
            c_ADDR_SR:    CP0_rdata = {16'd0, r_im, 8'd0, EXL, r_ie};
            c_ADDR_CAUSE: CP0_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'd0};
            c_ADDR_EPC:   CP0_rdata = r_epc;
            default:      CP0_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
